ifu_iccm_arb: RTL

IFU_ICCM_ARB -- requirements
Module: ifu_iccm_arb

---
 rtl/swerv_types.sv | 20 ++
 rtl/ifu_iccm_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/swerv_types.sv
// Shared types for the ICCM fetch/DMA arbiter.
// Arbitration states and DMA access-size encodings.
package swerv_types;

   typedef enum logic {
      ARB_NORM  = 1'b0,
      ARB_FORCE = 1'b1
   } arb_state_e;

   localparam logic [1:0] SZ_4B = 2'b10;
   localparam logic [1:0] SZ_8B = 2'b11;

   localparam int CNT_W   = 4;
   localparam int DATA_W  = 78;

   function automatic logic size_legal(input logic [2:0] sz);
      return (sz[1:0] == SZ_4B) || (sz[1:0] == SZ_8B);
   endfunction

endpackage

// File: rtl/ifu_iccm_arb.sv
// ICCM port arbiter between instruction fetch and DMA.
// Fetch has priority; a starvation counter forces a DMA grant.
module ifu_iccm_arb
   import swerv_types::*;
#(
   parameter int ICCM_BITS  = 16,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst_l,

   input  logic                   ifc_iccm_req,
   input  logic [ICCM_BITS-1:2]   ifc_iccm_addr,
   output logic                   ifc_iccm_gnt,
   output logic                   ifc_iccm_rvalid,

   input  logic                   dma_iccm_req,
   input  logic                   dma_iccm_write,
   input  logic [ICCM_BITS-1:2]   dma_iccm_addr,
   input  logic [2:0]             dma_iccm_size,
   input  logic [DATA_W-1:0]      dma_iccm_wdata,
   output logic                   dma_iccm_gnt,
   output logic                   dma_iccm_rvalid,
   output logic                   dma_iccm_err,

   output logic                   iccm_wren,
   output logic                   iccm_rden,
   output logic [ICCM_BITS-1:2]   iccm_rw_addr,
   output logic [2:0]             iccm_wr_size,
   output logic [DATA_W-1:0]      iccm_wr_data,

   output logic [CNT_W-1:0]       starve_cnt_o
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;

   arb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       starve_q, starve_d;
   logic                   ifc_rd_q, dma_rd_q, err_q;
   logic [ICCM_BITS-1:2]   addr_q;
   logic [2:0]             size_q;
   logic [DATA_W-1:0]      data_q;

   logic                   dma_ok;
   logic                   dma_acc;
   logic                   dma_rd;
   logic                   cmd_en;

   assign dma_ok = size_legal(dma_iccm_size);

   // Grants are suppressed while reset is asserted
   always_comb begin
      ifc_iccm_gnt = 1'b0;
      dma_iccm_gnt = 1'b0;
      if (rst_l) begin
         unique case (state_q)
            ARB_NORM: begin
               ifc_iccm_gnt = ifc_iccm_req;
               dma_iccm_gnt = dma_iccm_req & ~ifc_iccm_req;
            end
            ARB_FORCE: begin
               dma_iccm_gnt = dma_iccm_req;
               ifc_iccm_gnt = ifc_iccm_req & ~dma_iccm_req;
            end
            default: begin
               ifc_iccm_gnt = 1'b0;
               dma_iccm_gnt = 1'b0;
            end
         endcase
      end
   end

   assign dma_acc   = dma_iccm_gnt & dma_ok;
   assign dma_rd    = dma_acc & ~dma_iccm_write;
   assign iccm_wren = dma_acc & dma_iccm_write;
   assign iccm_rden = ifc_iccm_gnt | dma_rd;
   assign cmd_en    = iccm_wren | iccm_rden;

   // Idle cycles replay the last command to avoid toggling
   always_comb begin
      iccm_rw_addr = addr_q;
      iccm_wr_size = size_q;
      iccm_wr_data = data_q;
      if (ifc_iccm_gnt) begin
         iccm_rw_addr = ifc_iccm_addr;
         iccm_wr_size = 3'b000;
      end else if (dma_acc) begin
         iccm_rw_addr = dma_iccm_addr;
         iccm_wr_size = dma_iccm_write ? dma_iccm_size : 3'b000;
         if (dma_iccm_write) begin
            iccm_wr_data = dma_iccm_wdata;
         end
      end
   end

   always_comb begin
      starve_d = '0;
      if (dma_iccm_req && !dma_iccm_gnt) begin
         starve_d = (starve_q == CNT_SAT) ? CNT_SAT : starve_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_NORM: begin
            if (starve_d == STARVE_LIM) begin
               state_d = ARB_FORCE;
            end
         end
         ARB_FORCE: begin
            if (dma_iccm_gnt || !dma_iccm_req) begin
               state_d = ARB_NORM;
            end
         end
         default: state_d = ARB_NORM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state_q  <= ARB_NORM;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         ifc_rd_q <= 1'b0;
         dma_rd_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         ifc_rd_q <= ifc_iccm_gnt;
         dma_rd_q <= dma_rd;
         err_q    <= dma_iccm_gnt & ~dma_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         addr_q <= '0;
         size_q <= '0;
         data_q <= '0;
      end else if (cmd_en) begin
         addr_q <= iccm_rw_addr;
         size_q <= iccm_wr_size;
         data_q <= iccm_wr_data;
      end
   end

   assign ifc_iccm_rvalid = ifc_rd_q & rst_l;
   assign dma_iccm_rvalid = dma_rd_q & rst_l;
   assign dma_iccm_err    = err_q & rst_l;
   assign starve_cnt_o    = starve_q;

endmodule
